// File: rtl/bit_counter_4.sv
// 4-bit synchronous binary counter built from one toggle flip-flop per bit.
// A carry-enable chain makes every bit update on the same clock edge.

module bit_counter_4_tff #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // NOTE: combinational logic uses blocking '='; the register below uses '<=' so
    // every flip-flop in the chain samples the pre-edge state together.
    always_comb begin
        q_d = t_i ? ~q_q : q_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

module bit_counter_4 #(
    parameter logic [3:0] RESET_VALUE = 4'b0000,
    parameter bit         COUNT_DOWN  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic r1,
    output logic r2,
    output logic r3,
    output logic r4
);

    logic [3:0] count_q;
    logic [3:0] toggle_en;
    logic [2:0] carry_src;

    // Counting down toggles a bit when every lower bit is 0, so invert the chain.
    assign carry_src = count_q[2:0] ^ {3{COUNT_DOWN}};

    assign toggle_en[0] = 1'b1;
    assign toggle_en[1] = carry_src[0];
    assign toggle_en[2] = &carry_src[1:0];
    assign toggle_en[3] = &carry_src[2:0];

    for (genvar i = 0; i < 4; i++) begin : g_bit
        bit_counter_4_tff #(
            .INIT(RESET_VALUE[i])
        ) u_tff (
            .clk(clk),
            .rst(rst),
            .t_i(toggle_en[i]),
            .q_o(count_q[i])
        );
    end

    assign r1 = count_q[0];
    assign r2 = count_q[1];
    assign r3 = count_q[2];
    assign r4 = count_q[3];

endmodule

// File: tb/tb_bit_counter_4.sv
// Self-checking bench for bit_counter_4: an up-counting default instance and a
// down-counting instance with RESET_VALUE=0011, checked against a queued model.

module tb_bit_counter_4;

    logic clk;
    logic rst;
    logic up_r1, up_r2, up_r3, up_r4;
    logic dn_r1, dn_r2, dn_r3, dn_r4;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_up;
    logic [3:0] exp_dn;
    logic [3:0] up_val;
    logic [3:0] dn_val;
    logic [3:0] exp_up_q[$];
    logic [3:0] exp_dn_q[$];
    logic [3:0] dn_seq[5];

    bit_counter_4 dut_up (
        .clk(clk),
        .rst(rst),
        .r1 (up_r1),
        .r2 (up_r2),
        .r3 (up_r3),
        .r4 (up_r4)
    );

    bit_counter_4 #(
        .RESET_VALUE(4'b0011),
        .COUNT_DOWN (1'b1)
    ) dut_dn (
        .clk(clk),
        .rst(rst),
        .r1 (dn_r1),
        .r2 (dn_r2),
        .r3 (dn_r3),
        .r4 (dn_r4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model one count, queue the expectation, clock, then compare.
    task automatic tick(input string tag);
        logic [3:0] e_up;
        logic [3:0] e_dn;
        exp_up = exp_up + 4'd1;
        exp_dn = exp_dn - 4'd1;
        exp_up_q.push_back(exp_up);
        exp_dn_q.push_back(exp_dn);
        @(posedge clk);
        @(negedge clk);
        up_val = {up_r4, up_r3, up_r2, up_r1};
        dn_val = {dn_r4, dn_r3, dn_r2, dn_r1};
        if (exp_up_q.size() == 0 || exp_dn_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e_up = exp_up_q.pop_front();
            e_dn = exp_dn_q.pop_front();
            check({tag, "_up"}, 32'(up_val), 32'(e_up));
            check({tag, "_dn"}, 32'(dn_val), 32'(e_dn));
        end
    endtask

    initial begin
        int r4_high;
        int toggles[4];
        logic [3:0] prev;

        dn_seq[0] = 4'b0010;
        dn_seq[1] = 4'b0001;
        dn_seq[2] = 4'b0000;
        dn_seq[3] = 4'b1111;
        dn_seq[4] = 4'b1110;

        // Power-up reset held for 100 ns: outputs must stay at the reset value.
        rst    = 1'b0;
        exp_up = 4'b0000;
        exp_dn = 4'b0011;
        repeat (10) begin
            @(negedge clk);
            check("por_up", 32'({up_r4, up_r3, up_r2, up_r1}), 32'(4'b0000));
            check("por_dn", 32'({dn_r4, dn_r3, dn_r2, dn_r1}), 32'(4'b0011));
        end

        // Release between edges and count 20 edges.
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick("count");
            if (i < 5) check("dn_release_seq", 32'(dn_val), 32'(dn_seq[i]));
            if (i == 0) check("first_edge_up", 32'(up_val), 32'(4'b0001));
        end
        check("after_20_edges", 32'(up_val), 32'(4'b0100));

        // Advance to 1010, then assert reset between edges.
        while (exp_up != 4'b1010) tick("to_1010");
        check("at_1010", 32'(up_val), 32'(4'b1010));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_up", 32'({up_r4, up_r3, up_r2, up_r1}), 32'(4'b0000));
        check("async_rst_dn", 32'({dn_r4, dn_r3, dn_r2, dn_r1}), 32'(4'b0011));
        exp_up = 4'b0000;
        exp_dn = 4'b0011;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_up", 32'({up_r4, up_r3, up_r2, up_r1}), 32'(4'b0000));
            check("rst_hold_dn", 32'({dn_r4, dn_r3, dn_r2, dn_r1}), 32'(4'b0011));
        end

        // Wrap: 16 edges from 0000 return to 0000; MSB high for 8 of them.
        rst     = 1'b1;
        r4_high = 0;
        for (int i = 1; i <= 16; i++) begin
            tick("wrap");
            if (i == 15) check("edge15_up", 32'(up_val), 32'(4'b1111));
            if (up_val[3]) r4_high++;
        end
        check("wrap_up", 32'(up_val), 32'(4'b0000));
        check("r4_high_cycles", 32'(r4_high), 32'd8);

        // Divide-by-2/4/8/16: count per-bit transitions over 32 edges.
        for (int b = 0; b < 4; b++) toggles[b] = 0;
        prev = up_val;
        for (int i = 0; i < 32; i++) begin
            tick("window");
            for (int b = 0; b < 4; b++) begin
                if (up_val[b] != prev[b]) toggles[b]++;
            end
            prev = up_val;
        end
        check("r1_toggles", 32'(toggles[0]), 32'd32);
        check("r2_toggles", 32'(toggles[1]), 32'd16);
        check("r3_toggles", 32'(toggles[2]), 32'd8);
        check("r4_toggles", 32'(toggles[3]), 32'd4);

        check("scoreboard_drained", 32'(exp_up_q.size() + exp_dn_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bit_counter_4.md
Name: bit_counter_4

Overview:
- 4-bit synchronous binary counter presented as four discrete bit outputs r1..r4.
- Implemented structurally: one toggle flip-flop per bit, with a carry-enable chain (bit n toggles when all lower bits are 1, or all 0 in down mode).
- Used as a lab/demo block and as a free-running cycle counter driving LEDs or downstream logic.
- No handshake; counts every clock while out of reset.

Parameters:
- RESET_VALUE, 4'b0000, count value loaded asynchronously on reset; r1 = bit 0.
- COUNT_DOWN, 0, 0 = increment each cycle; 1 = decrement each cycle.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-low reset; rst=0 forces counter to RESET_VALUE.
- r1  output  1  count bit 0 (LSB).
- r2  output  1  count bit 1.
- r3  output  1  count bit 2.
- r4  output  1  count bit 3 (MSB).

Behaviour:
- Internal state: 4 registers, q[3:0].
  - Outputs are driven directly from q: r1=q[0], r2=q[1], r3=q[2], r4=q[3].
  - No combinational path from inputs to outputs.
- Reset:
  - While rst=0, q = RESET_VALUE, applied asynchronously (takes effect without a clock edge).
  - Default reset value: r4..r1 = 0000.
  - Reset asserted mid-count clears immediately, regardless of clk.
- Release:
  - rst 0->1 takes effect at the first rising clk edge where rst=1 at the edge.
  - At that edge q becomes RESET_VALUE±1; there is no extra dead cycle.
- Count rule, up mode (COUNT_DOWN=0):
  - Each rising edge, q <= q + 1 mod 16.
  - Toggle enables: t0=1, t1=q0, t2=q0&q1, t3=q0&q1&q2.
- Count rule, down mode (COUNT_DOWN=1):
  - q <= q - 1 mod 16, with toggle enables on inverted lower bits.
- Wrap-around:
  - Up mode: 1111 -> 0000.
  - Down mode: 0000 -> 1111.
  - No sticky flag; the period is exactly 16 cycles.
- Timing:
  - All four bits update on the same edge (synchronous carry, not ripple).
  - No intermediate glitch codes at register outputs.
  - Latency: output reflects the new count one clock after the edge that computes it, i.e. registered.
- Simultaneous events:
  - rst low at a clock edge: reset wins.
  - rst rising coincident with a clk edge is illegal; integrators must synchronize reset deassertion.
- X-handling: outputs must never be X after the first reset assertion.

Test Plan:
- Power-up reset: clk period 10 ns, rst=0 for 100 ns -> r4..r1 = 0000 throughout, with no change on clock edges.
- Release and count: rst=1 at t=100 ns, run 200 ns (20 edges) -> sequence 0001,0010,...,1111,0000,0001,...
  - After 20 edges, value = 20 mod 16 = 0100.
  - Each step differs from the previous by exactly +1.
- Wrap: count from 0000 for 16 edges -> value returns to 0000.
  - Edge 15 shows 1111.
  - r4 is high for exactly 8 consecutive cycles per period.
- Async mid-count reset: drive rst=0 between clock edges while the count is 1010 -> outputs become 0000 before the next edge and stay 0000 while rst=0.
- Bit frequencies over a 32-cycle window: r1 toggles every cycle, r2 every 2, r3 every 4, r4 every 8 -> divide-by-2/4/8/16 waveforms.
- Parameter variant: COUNT_DOWN=1, RESET_VALUE=4'b0011 -> after reset release, edges give 0010,0001,0000,1111,1110.
